// File: rtl/pulse_id_pkg.sv
// Shared types, default widths and helpers for the multi-channel pulse identifier.
package pulse_id_pkg;

    localparam int unsigned DefNumSensors  = 4;
    localparam int unsigned DefSelW        = 4;
    localparam int unsigned DefCntW        = 8;
    localparam int unsigned DefTsW         = 24;
    localparam int unsigned DefPolyW       = 17;
    localparam int unsigned DefIterShift   = 4;
    localparam int unsigned DefTimeoutTick = 72000;
    localparam int unsigned DefSettleTick  = 3750;

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StSettle,
        StPoly,
        StOffsetWait,
        StCalc,
        StReady,
        StDrain
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pulse_window_capture.sv
// Per-channel arrival capture: registered activity, seen mask, timestamps,
// first/second arbitration and the collection window timer.
module pulse_window_capture
    import pulse_id_pkg::*;
#(
    parameter int unsigned NUM_SENSORS   = DefNumSensors,
    parameter int unsigned SEL_W         = DefSelW,
    parameter int unsigned CNT_W         = DefCntW,
    parameter int unsigned TS_W          = DefTsW,
    parameter int unsigned TIMEOUT_TICKS = DefTimeoutTick
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_SENSORS*CNT_W-1:0] avl_blocks_nb_i,
    input  logic [TS_W-1:0]              sys_ts_i,
    input  logic                         capture_en_i,
    input  logic                         timer_clr_i,
    input  logic                         seen_clr_i,
    output logic [NUM_SENSORS-1:0]       active_o,
    output logic [NUM_SENSORS-1:0]       seen_o,
    output logic [NUM_SENSORS*TS_W-1:0]  ts_cap_o,
    output logic [SEL_W-1:0]             first_o,
    output logic [SEL_W-1:0]             second_o,
    output logic                         first_vld_o,
    output logic                         second_vld_o,
    output logic                         timeout_o,
    output logic                         all_seen_o,
    output logic                         drained_o
);

    localparam int unsigned TmrW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TmrW-1:0] TmrMax = TmrW'(TIMEOUT_TICKS);

    logic [NUM_SENSORS*CNT_W-1:0] avl_q;
    logic [NUM_SENSORS-1:0]       seen_q, seen_d, new_mask;
    logic [TS_W-1:0]              ts_cap_q [NUM_SENSORS];
    logic [SEL_W-1:0]             first_q, first_d, second_q, second_d;
    logic                         first_vld_q, first_vld_d, second_vld_q, second_vld_d;
    logic [TmrW-1:0]              timer_q, timer_d;
    logic                         window_open;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_chan
        assign active_o[g]                 = |avl_q[g*CNT_W +: CNT_W];
        assign ts_cap_o[g*TS_W +: TS_W]    = ts_cap_q[g];
    end

    assign window_open = capture_en_i && (timer_q < TmrMax);
    assign timeout_o   = (timer_q == TmrMax);
    assign new_mask    = active_o & ~seen_q & {NUM_SENSORS{window_open}};
    assign timer_d     = timer_clr_i ? '0 : (timeout_o ? timer_q : timer_q + 1'b1);

    // Lowest index wins ties, both for first and for second within one cycle.
    always_comb begin
        seen_d       = seen_q | new_mask;
        first_d      = first_q;
        second_d     = second_q;
        first_vld_d  = first_vld_q;
        second_vld_d = second_vld_q;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (new_mask[i]) begin
                if (!first_vld_d) begin
                    first_d     = SEL_W'(i);
                    first_vld_d = 1'b1;
                end else if (!second_vld_d) begin
                    second_d     = SEL_W'(i);
                    second_vld_d = 1'b1;
                end
            end
        end
        if (seen_clr_i) begin
            seen_d       = '0;
            first_d      = '0;
            second_d     = '0;
            first_vld_d  = 1'b0;
            second_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            avl_q        <= '0;
            seen_q       <= '0;
            first_q      <= '0;
            second_q     <= '0;
            first_vld_q  <= 1'b0;
            second_vld_q <= 1'b0;
            timer_q      <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                ts_cap_q[i] <= '0;
            end
        end else begin
            avl_q        <= avl_blocks_nb_i;
            seen_q       <= seen_d;
            first_q      <= first_d;
            second_q     <= second_d;
            first_vld_q  <= first_vld_d;
            second_vld_q <= second_vld_d;
            timer_q      <= timer_d;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (new_mask[i]) begin
                    ts_cap_q[i] <= sys_ts_i;
                end
            end
        end
    end

    assign seen_o       = seen_q;
    assign first_o      = first_q;
    assign second_o     = second_q;
    assign first_vld_o  = first_vld_q;
    assign second_vld_o = second_vld_q;
    assign all_seen_o   = &seen_q;
    assign drained_o    = ((seen_q & active_o) == '0);

endmodule

// File: rtl/pulse_identifier_multi.sv
// Multi-channel pulse identifier: drives the polynomial/offset handshakes and
// turns captured arrival timestamps into per-channel pulse IDs.
module pulse_identifier_multi
    import pulse_id_pkg::*;
#(
    parameter int unsigned NUM_SENSORS   = DefNumSensors,
    parameter int unsigned SEL_W         = DefSelW,
    parameter int unsigned CNT_W         = DefCntW,
    parameter int unsigned TS_W          = DefTsW,
    parameter int unsigned POLY_W        = DefPolyW,
    parameter int unsigned ITER_SHIFT    = DefIterShift,
    parameter int unsigned TIMEOUT_TICKS = DefTimeoutTick,
    parameter int unsigned SETTLE_TICKS  = DefSettleTick
) (
    input  logic                          clk_72MHz,
    input  logic                          reset,
    input  logic [TS_W-1:0]               sys_ts,
    input  logic [NUM_SENSORS*CNT_W-1:0]  avl_blocks_nb,
    output logic                          poly_enable,
    output logic [SEL_W-1:0]              poly_sel_a,
    output logic [SEL_W-1:0]              poly_sel_b,
    input  logic                          poly_ready,
    input  logic [POLY_W-1:0]             polynomial,
    input  logic [TS_W-1:0]               ts_first_data,
    output logic                          offset_enable,
    input  logic                          offset_ready,
    input  logic [POLY_W-1:0]             offset,
    output logic [NUM_SENSORS*POLY_W-1:0] pulse_id,
    output logic [NUM_SENSORS-1:0]        pulse_valid,
    output logic                          ready,
    input  logic                          ack,
    output logic [7:0]                    err_timeout_cnt,
    output logic [7:0]                    err_match_cnt
);

    localparam int unsigned SetW = $clog2(SETTLE_TICKS + 1);
    localparam logic [SetW-1:0]  SettleLast = SetW'(SETTLE_TICKS - 1);
    localparam logic [SEL_W-1:0] LastIdx    = SEL_W'(NUM_SENSORS - 1);

    state_e               state_q, state_d;
    logic [SetW-1:0]      settle_q, settle_d;
    logic                 arm_q, arm_d;
    logic                 offs_done_q, offs_done_d;
    logic [TS_W-1:0]      ts_ref_q, ts_ref_d;
    logic [POLY_W-1:0]    offset_q, offset_d;
    logic [SEL_W-1:0]     calc_idx_q, calc_idx_d;
    logic [POLY_W-1:0]    pid_q [NUM_SENSORS];
    logic [POLY_W-1:0]    pid_d [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] pvld_q, pvld_d;
    logic [7:0]           errt_q, errt_d, errm_q, errm_d;

    logic [NUM_SENSORS-1:0]      active, seen;
    logic [NUM_SENSORS*TS_W-1:0] ts_cap;
    logic [TS_W-1:0]             cap_arr [NUM_SENSORS];
    logic [SEL_W-1:0]            first_sel, second_sel;
    logic                        first_vld, second_vld, timeout, all_seen, drained;
    logic                        capture_en, timer_clr, seen_clr;
    logic [TS_W-1:0]             cap_ts, delta;
    logic                        seen_k;
    logic [POLY_W-1:0]           calc_pid;

    assign capture_en = (state_q == StIdle) || (state_q == StCollect) || (state_q == StSettle)
                        || (state_q == StPoly) || (state_q == StOffsetWait);
    assign timer_clr  = (state_q == StIdle);
    assign seen_clr   = (state_q == StDrain) && drained;

    pulse_window_capture #(
        .NUM_SENSORS   (NUM_SENSORS),
        .SEL_W         (SEL_W),
        .CNT_W         (CNT_W),
        .TS_W          (TS_W),
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_capture (
        .clk_i           (clk_72MHz),
        .rst_i           (reset),
        .avl_blocks_nb_i (avl_blocks_nb),
        .sys_ts_i        (sys_ts),
        .capture_en_i    (capture_en),
        .timer_clr_i     (timer_clr),
        .seen_clr_i      (seen_clr),
        .active_o        (active),
        .seen_o          (seen),
        .ts_cap_o        (ts_cap),
        .first_o         (first_sel),
        .second_o        (second_sel),
        .first_vld_o     (first_vld),
        .second_vld_o    (second_vld),
        .timeout_o       (timeout),
        .all_seen_o      (all_seen),
        .drained_o       (drained)
    );

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_flat
        assign cap_arr[g]                      = ts_cap[g*TS_W +: TS_W];
        assign pulse_id[g*POLY_W +: POLY_W]    = pid_q[g];
    end

    // Modulo subtraction absorbs sys_ts wrap; the first channel is pinned to zero.
    always_comb begin
        cap_ts = '0;
        seen_k = 1'b0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            if (calc_idx_q == SEL_W'(k)) begin
                cap_ts = cap_arr[k];
                seen_k = seen[k];
            end
        end
        delta = cap_ts - ts_ref_q;
        if (first_vld && (calc_idx_q == first_sel)) begin
            delta = '0;
        end
        calc_pid = offset_q + POLY_W'(delta >> ITER_SHIFT);
    end

    always_comb begin
        state_d       = state_q;
        settle_d      = '0;
        arm_d         = 1'b0;
        offs_done_d   = offs_done_q;
        ts_ref_d      = ts_ref_q;
        offset_d      = offset_q;
        calc_idx_d    = '0;
        pid_d         = pid_q;
        pvld_d        = pvld_q;
        errt_d        = errt_q;
        errm_d        = errm_q;
        poly_enable   = 1'b0;
        offset_enable = 1'b0;
        ready         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|active) state_d = StCollect;
            end
            StCollect: begin
                if (second_vld) begin
                    state_d = StSettle;
                end else if (timeout) begin
                    errt_d  = sat_inc8(errt_q);
                    state_d = StDrain;
                end
            end
            StSettle: begin
                if (settle_q == SettleLast) state_d = StPoly;
                else                        settle_d = settle_q + 1'b1;
            end
            StPoly: begin
                poly_enable = 1'b1;
                // Only a ready seen after a low phase counts as completion.
                arm_d = arm_q | ~poly_ready;
                if (arm_q && poly_ready) begin
                    arm_d    = 1'b0;
                    ts_ref_d = ts_first_data;
                    if (polynomial == '0) begin
                        errm_d  = sat_inc8(errm_q);
                        state_d = StDrain;
                    end else begin
                        offs_done_d = 1'b0;
                        state_d     = StOffsetWait;
                    end
                end
            end
            StOffsetWait: begin
                offset_enable = 1'b1;
                if (!offs_done_q) begin
                    arm_d = arm_q | ~offset_ready;
                    if (arm_q && offset_ready) begin
                        arm_d = 1'b0;
                        if (offset == '0) begin
                            errm_d  = sat_inc8(errm_q);
                            state_d = StDrain;
                        end else begin
                            offset_d    = offset;
                            offs_done_d = 1'b1;
                        end
                    end
                end else if (all_seen || timeout) begin
                    state_d = StCalc;
                end
            end
            StCalc: begin
                for (int k = 0; k < NUM_SENSORS; k++) begin
                    if (calc_idx_q == SEL_W'(k)) begin
                        pid_d[k]  = seen_k ? calc_pid : '0;
                        pvld_d[k] = seen_k;
                    end
                end
                if (calc_idx_q == LastIdx) state_d = StReady;
                else                       calc_idx_d = calc_idx_q + 1'b1;
            end
            StReady: begin
                ready = 1'b1;
                if (ack) state_d = StDrain;
            end
            StDrain: begin
                if (drained) begin
                    for (int k = 0; k < NUM_SENSORS; k++) begin
                        pid_d[k] = '0;
                    end
                    pvld_d  = '0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_72MHz or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            settle_q    <= '0;
            arm_q       <= 1'b0;
            offs_done_q <= 1'b0;
            ts_ref_q    <= '0;
            offset_q    <= '0;
            calc_idx_q  <= '0;
            pvld_q      <= '0;
            errt_q      <= '0;
            errm_q      <= '0;
            for (int k = 0; k < NUM_SENSORS; k++) begin
                pid_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            arm_q       <= arm_d;
            offs_done_q <= offs_done_d;
            ts_ref_q    <= ts_ref_d;
            offset_q    <= offset_d;
            calc_idx_q  <= calc_idx_d;
            pvld_q      <= pvld_d;
            errt_q      <= errt_d;
            errm_q      <= errm_d;
            pid_q       <= pid_d;
        end
    end

    assign poly_sel_a      = first_sel;
    assign poly_sel_b      = second_sel;
    assign pulse_valid     = pvld_q;
    assign err_timeout_cnt = errt_q;
    assign err_match_cnt   = errm_q;

endmodule
